// File: rtl/common.sv
// Shared types and constants for the NMI arbiter and its button front-ends.
package common;

    localparam int unsigned DEBOUNCE_FRAMES     = 2;
    localparam int unsigned NMI_TIMEOUT_FRAMES  = 4;
    localparam int unsigned SERVICE_LOW_STROBES = 2;

    localparam logic [15:0] NMI_VECTOR  = 16'h0066;
    localparam logic [15:0] STATUS_PORT = 16'hFEFF;

    typedef enum logic [1:0] {
        NMI_SRC_NONE  = 2'd0,
        NMI_SRC_MAGIC = 2'd1,
        NMI_SRC_DIV   = 2'd2,
        NMI_SRC_PAUSE = 2'd3
    } nmi_src_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ASSERT,
        ST_SERVICE,
        ST_HOLDOFF
    } arb_state_t;

    // Pending vector bit order: [0] magic, [1] div, [2] pause.
    function automatic nmi_src_t pick_winner(input logic [2:0] pend);
        if (pend[0]) return NMI_SRC_MAGIC;
        if (pend[1]) return NMI_SRC_DIV;
        if (pend[2]) return NMI_SRC_PAUSE;
        return NMI_SRC_NONE;
    endfunction

    function automatic logic [2:0] src_mask(input nmi_src_t src);
        case (src)
            NMI_SRC_MAGIC: return 3'b001;
            NMI_SRC_DIV:   return 3'b010;
            NMI_SRC_PAUSE: return 3'b100;
            default:       return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/cpu_bus.sv
// Z80 bus strobes as seen by peripherals; all strobes active-high.
interface cpu_bus;
    logic        mreq;
    logic        m1;
    logic        rd;
    logic        wr;
    logic        ioreq;
    logic [15:0] a;
    logic [7:0]  d;

    modport arb (input mreq, m1, rd, wr, ioreq, a, d);
    modport cpu (output mreq, m1, rd, wr, ioreq, a, d);
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus frame-strobe debouncer; emits a one-cycle pulse
// on each accepted 0->1 transition.
module btn_debounce
    import common::*;
(
    input  logic rst_n,
    input  logic clk28,
    input  logic btn,
    input  logic strobe,
    output logic rise
);
    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          sync1_q, sync2_q;
    logic          sample_q, sample_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sample_q <= 1'b0;
            level_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn;
            sync2_q  <= sync1_q;
            sample_q <= sample_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
        end
    end

    // cnt counts consecutive strobes that saw the same synchronised level.
    always_comb begin
        sample_d = sample_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        if (strobe) begin
            if (sync2_q == sample_q) begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            end else begin
                sample_d = sync2_q;
                cnt_d    = CW'(1);
            end
            if (cnt_d >= CW'(DEBOUNCE_FRAMES)) level_d = sync2_q;
        end
    end

    assign rise = level_d & ~level_q;

endmodule

// File: rtl/nmi_arbiter.sv
// Arbitrates magic/div/pause NMI requests onto the single Z80 NMI line,
// with frame-aligned assertion, vector-fetch acknowledge and a status port.
module nmi_arbiter
    import common::*;
(
    input  logic       rst_n,
    input  logic       clk28,
    cpu_bus.arb        bus,
    input  logic       n_int,
    input  logic       n_int_next,
    input  logic       btn_magic,
    input  logic       btn_div,
    input  logic       btn_pause,
    input  logic       magic_busy,
    input  logic       div_busy,
    input  logic       magic_map,
    output logic       n_nmi,
    output nmi_src_t   nmi_src,
    output logic       nmi_ack,
    output logic [7:0] d_out,
    output logic       d_out_active
);
    arb_state_t state_q, state_d;
    nmi_src_t   src_q, src_d;
    logic [2:0] pend_q, pend_d;
    logic [2:0] tcnt_q, tcnt_d;
    logic [1:0] lcnt_q, lcnt_d;
    logic       timeout_q, timeout_d;
    logic       rd_act_q, rd_act_d;

    logic       strobe, vec_fetch, vec_ack, expire, svc_done, owner_busy;
    logic       st_hit, rd_hit, wr_clr;
    logic [2:0] rise, set_req;

    assign strobe    = n_int & ~n_int_next;
    assign vec_fetch = bus.m1 & bus.mreq & (bus.a == NMI_VECTOR);
    assign vec_ack   = (state_q == ST_ASSERT) & vec_fetch;
    assign st_hit    = magic_map & bus.ioreq & (bus.a == STATUS_PORT);
    assign rd_hit    = st_hit & bus.rd;
    assign wr_clr    = st_hit & bus.wr & bus.d[7];
    assign owner_busy = (src_q == NMI_SRC_DIV) ? div_busy : magic_busy;

    btn_debounce u_db_magic (.rst_n(rst_n), .clk28(clk28), .btn(btn_magic), .strobe(strobe), .rise(rise[0]));
    btn_debounce u_db_div   (.rst_n(rst_n), .clk28(clk28), .btn(btn_div),   .strobe(strobe), .rise(rise[1]));
    btn_debounce u_db_pause (.rst_n(rst_n), .clk28(clk28), .btn(btn_pause), .strobe(strobe), .rise(rise[2]));

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Vector fetch is checked before expiry so a same-cycle fetch wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (|pend_q) state_d = ST_SYNC;
            ST_SYNC:    if (strobe)  state_d = ST_ASSERT;
            ST_ASSERT: begin
                if (vec_fetch)   state_d = ST_SERVICE;
                else if (expire) state_d = ST_HOLDOFF;
            end
            ST_SERVICE: if (svc_done) state_d = ST_HOLDOFF;
            ST_HOLDOFF: if (strobe)   state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        n_nmi        = ~((state_q == ST_ASSERT) & ~vec_fetch);
        nmi_ack      = vec_ack;
        nmi_src      = src_q;
        d_out_active = rd_act_q;
        d_out        = {timeout_q, 1'b0, src_q, pend_q[2], pend_q[1], pend_q[0], n_nmi};
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            src_q     <= NMI_SRC_NONE;
            pend_q    <= '0;
            tcnt_q    <= '0;
            lcnt_q    <= '0;
            timeout_q <= 1'b0;
            rd_act_q  <= 1'b0;
        end else begin
            src_q     <= src_d;
            pend_q    <= pend_d;
            tcnt_q    <= tcnt_d;
            lcnt_q    <= lcnt_d;
            timeout_q <= timeout_d;
            rd_act_q  <= rd_act_d;
        end
    end

    always_comb begin
        tcnt_d = '0;
        if (state_q == ST_ASSERT) begin
            tcnt_d = tcnt_q;
            if (strobe && tcnt_q != '1) tcnt_d = tcnt_q + 1'b1;
        end
        expire = (state_q == ST_ASSERT) & strobe & (tcnt_d >= 3'(NMI_TIMEOUT_FRAMES));

        lcnt_d = '0;
        if (state_q == ST_SERVICE) begin
            lcnt_d = lcnt_q;
            if (strobe) begin
                if (owner_busy)        lcnt_d = '0;
                else if (lcnt_q != '1) lcnt_d = lcnt_q + 1'b1;
            end
        end
        svc_done = (state_q == ST_SERVICE) & strobe & ~owner_busy &
                   (lcnt_d >= 2'(SERVICE_LOW_STROBES));

        src_d = src_q;
        if (state_q == ST_IDLE && |pend_q)     src_d = pick_winner(pend_q);
        else if (state_q == ST_HOLDOFF && strobe) src_d = NMI_SRC_NONE;

        // The source being serviced cannot re-arm itself until service ends.
        set_req = rise;
        if (state_q == ST_SERVICE) set_req = rise & ~src_mask(src_q);
        pend_d = pend_q | set_req;
        if (vec_ack) pend_d = pend_d & ~src_mask(src_q);

        timeout_d = (timeout_q & ~wr_clr) | (expire & ~vec_fetch);
        rd_act_d  = rd_hit;
    end

endmodule
